fredkin_swap_array: RTL and testbench

Parametrised array of controlled-swap (Fredkin) channels for the programmable-logic tile. Each channel routes an operand pair (a, b) to (x, y), either straight or crossed. The swap selects come from direct pins, from a serially loaded configuration register, or from that register modulated by an alternating phase. Outputs are registered with a valid strobe, so the array can sit directly in the tile's pipelined datapath.

---
 rtl/fredkin_pkg.sv | 11 +
 rtl/fredkin_cell.sv | 17 +
 rtl/fredkin_swap_array.sv | 106 ++++++++++
 tb/tb_fredkin_swap_array.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fredkin_pkg.sv
// Shared definitions for the Fredkin controlled-swap array.
package fredkin_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_CONFIG = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_INVERT = 2'd3
  } mode_t;

endpackage : fredkin_pkg

// File: rtl/fredkin_cell.sv
// One controlled-swap channel: routes (a, b) straight or crossed onto (x, y).
module fredkin_cell #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    x = s ? b : a;
    y = s ? a : b;
  end

endmodule : fredkin_cell

// File: rtl/fredkin_swap_array.sv
// Array of Fredkin swap channels with serially loaded swap configuration,
// phase-modulated toggle mode and registered outputs.
module fredkin_swap_array
  import fredkin_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  input  logic [CHANNELS-1:0]       sel_direct,
  input  logic [1:0]                mode,
  input  logic                      cfg_sdi,
  input  logic                      cfg_shift,
  input  logic                      cfg_commit,
  output logic [CHANNELS*WIDTH-1:0] x,
  output logic [CHANNELS*WIDTH-1:0] y,
  output logic                      out_valid,
  output logic                      cfg_sdo
);

  logic [CHANNELS-1:0]       r_shadow;
  logic [CHANNELS-1:0]       r_active;
  logic                      r_phase;
  logic [CHANNELS*WIDTH-1:0] r_x;
  logic [CHANNELS*WIDTH-1:0] r_y;
  logic                      r_out_valid;

  logic [CHANNELS-1:0]       w_sel;
  logic [CHANNELS-1:0]       w_shadow_nxt;
  logic [CHANNELS*WIDTH-1:0] w_x;
  logic [CHANNELS*WIDTH-1:0] w_y;
  mode_t                     w_mode;

  assign w_mode = mode_t'(mode);

  always_comb begin
    w_sel = '0;
    case (w_mode)
      MODE_DIRECT: w_sel = sel_direct;
      MODE_CONFIG: w_sel = r_active;
      MODE_TOGGLE: w_sel = r_active ^ {CHANNELS{r_phase}};
      MODE_INVERT: w_sel = ~r_active;
      default:     w_sel = '0;
    endcase
  end

  generate
    if (CHANNELS == 1) begin : g_shadow_single
      assign w_shadow_nxt = cfg_sdi;
    end else begin : g_shadow_multi
      assign w_shadow_nxt = {r_shadow[CHANNELS-2:0], cfg_sdi};
    end
  endgenerate

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_cell
      fredkin_cell #(
        .WIDTH(WIDTH)
      ) u_cell (
        .a(a[k*WIDTH +: WIDTH]),
        .b(b[k*WIDTH +: WIDTH]),
        .s(w_sel[k]),
        .x(w_x[k*WIDTH +: WIDTH]),
        .y(w_y[k*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Commit samples the pre-edge shadow and routes the same-edge beat with the
  // pre-commit active/phase, so all three registers share one edge cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      r_active    <= '0;
      r_phase     <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (cfg_shift) begin
        r_shadow <= w_shadow_nxt;
      end
      if (cfg_commit) begin
        r_active <= r_shadow;
        r_phase  <= 1'b0;
      end else if (in_valid && (w_mode == MODE_TOGGLE)) begin
        r_phase <= ~r_phase;
      end
      if (in_valid) begin
        r_x <= w_x;
        r_y <= w_y;
      end
      r_out_valid <= in_valid;
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign out_valid = r_out_valid;
  assign cfg_sdo   = r_shadow[CHANNELS-1];

endmodule : fredkin_swap_array

// File: tb/tb_fredkin_swap_array.sv
// Scoreboard bench for fredkin_swap_array (CHANNELS=4, WIDTH=4).
module tb_fredkin_swap_array;

  localparam int CH = 4;
  localparam int W  = 4;
  localparam int N  = CH * W;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          in_valid   = 1'b0;
  logic [N-1:0]  a          = '0;
  logic [N-1:0]  b          = '0;
  logic [CH-1:0] sel_direct = '0;
  logic [1:0]    mode       = '0;
  logic          cfg_sdi    = 1'b0;
  logic          cfg_shift  = 1'b0;
  logic          cfg_commit = 1'b0;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic          out_valid;
  logic          cfg_sdo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
  } exp_t;

  exp_t         q[$];
  logic [N-1:0] hold_x = '0;
  logic [N-1:0] hold_y = '0;

  bit m_shadow[CH];
  bit m_active[CH];
  bit m_phase;

  fredkin_swap_array #(
    .CHANNELS(CH),
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .sel_direct(sel_direct),
    .mode(mode),
    .cfg_sdi(cfg_sdi),
    .cfg_shift(cfg_shift),
    .cfg_commit(cfg_commit),
    .x(x),
    .y(y),
    .out_valid(out_valid),
    .cfg_sdo(cfg_sdo)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_shadow[k] = 1'b0;
      m_active[k] = 1'b0;
    end
    m_phase = 1'b0;
    q.delete();
    hold_x = '0;
    hold_y = '0;
  endtask

  // Drive one cycle; the reference model advances on the same edge.
  task automatic step(bit v, logic [N-1:0] ia, logic [N-1:0] ib, logic [CH-1:0] sd,
                      logic [1:0] md, bit sh, bit sdi, bit cm,
                      bit lit = 1'b0, logic [N-1:0] lx = '0, logic [N-1:0] ly = '0);
    exp_t e;
    bit   old_shadow[CH];
    in_valid   = v;
    a          = ia;
    b          = ib;
    sel_direct = sd;
    mode       = md;
    cfg_shift  = sh;
    cfg_sdi    = sdi;
    cfg_commit = cm;
    @(posedge clk);
    if (v) begin
      for (int k = 0; k < CH; k++) begin
        bit s;
        case (md)
          2'd0:    s = sd[k];
          2'd1:    s = m_active[k];
          2'd2:    s = m_active[k] ^ m_phase;
          default: s = !m_active[k];
        endcase
        e.x[k*W +: W] = s ? ib[k*W +: W] : ia[k*W +: W];
        e.y[k*W +: W] = s ? ia[k*W +: W] : ib[k*W +: W];
      end
      if (lit) begin
        e.x = lx;
        e.y = ly;
      end
      q.push_back(e);
    end
    old_shadow = m_shadow;
    if (cm) begin
      m_active = old_shadow;
      m_phase  = 1'b0;
    end else if (v && md == 2'd2) begin
      m_phase = !m_phase;
    end
    if (sh) begin
      for (int k = CH - 1; k > 0; k--) m_shadow[k] = old_shadow[k-1];
      m_shadow[0] = sdi;
    end
    #1;
    check("cfg_sdo", {31'd0, cfg_sdo}, {31'd0, m_shadow[CH-1]});
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift(bit sdi);
    step(1'b0, '0, '0, '0, 2'd0, 1'b1, sdi, 1'b0);
  endtask

  task automatic commit();
    step(1'b0, '0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: pops an expectation per presented beat, otherwise checks hold.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got out_valid=1, expected no beat (t=%0t)", $time);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("x", x, e.x);
            check("y", y, e.y);
            hold_x = e.x;
            hold_y = e.y;
          end
        end else begin
          check("x_hold", x, hold_x);
          check("y_hold", y, hold_y);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_cfg_sdo", {31'd0, cfg_sdo}, 32'd0);
    rst_n = 1'b1;

    // DIRECT routing
    idle();
    check("pre_beat_x", x, 0);
    step(1'b1, 16'h4321, 16'h8765, 4'b0101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4725, 16'h8361);
    check("direct_out_valid", {31'd0, out_valid}, 32'd1);

    // Serial load 1,0,0,1 then CONFIG beat
    shift(1'b1); shift(1'b0); shift(1'b0); shift(1'b1);
    check("sdo_first_bit", {31'd0, cfg_sdo}, 32'd1);
    commit();
    step(1'b1, 16'hAAAA, 16'h5555, '0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5AA5, 16'hA55A);

    // TOGGLE with active=0000
    for (int i = 0; i < CH; i++) shift(1'b0);
    commit();
    step(1'b1, 16'h1111, 16'h2222, '0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222);
    step(1'b1, 16'h1111, 16'h2222, '0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2222, 16'h1111);
    step(1'b1, 16'h1111, 16'h2222, '0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222);
    commit();
    step(1'b1, 16'h1111, 16'h2222, '0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222);

    // Shift and commit together: shadow 1100 -> active 1100, shadow 1001
    shift(1'b1); shift(1'b1); shift(1'b0); shift(1'b0);
    step(1'b0, '0, '0, '0, 2'd0, 1'b1, 1'b1, 1'b1);
    check("simul_sdo", {31'd0, cfg_sdo}, 32'd1);
    step(1'b1, 16'h1234, 16'h5678, '0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5634, 16'h1278);
    commit();
    step(1'b1, 16'hAAAA, 16'h5555, '0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5AA5, 16'hA55A);

    // Beat coincident with commit routes with old active (1001)
    for (int i = 0; i < CH; i++) shift(1'b0);
    step(1'b1, 16'h1234, 16'h5678, '0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5238, 16'h1674);
    step(1'b1, 16'h000F, 16'h00F0, '0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00F0, 16'h000F);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), N'($urandom), N'($urandom), CH'($urandom),
           2'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
           1'($urandom_range(0, 7) == 0));
    end

    // Idle hold
    step(1'b1, 16'hC3A5, 16'h5A3C, 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset mid-cycle
    for (int i = 0; i < CH; i++) shift(1'b1);
    step(1'b1, 16'hBEEF, 16'h1357, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_x", x, 0);
    check("async_y", y, 0);
    check("async_cfg_sdo", {31'd0, cfg_sdo}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Post-reset: active and phase cleared
    idle();
    step(1'b1, 16'h9876, 16'h0123, '0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9876, 16'h0123);
    step(1'b1, 16'h9876, 16'h0123, '0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9876, 16'h0123);
    idle();
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fredkin_swap_array
